// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: eight-function bitwise unit on WIDTH-bit operands, optional accumulator as left operand; LOGIC_UNIT_PARITY_EN adds a parity output.
// Latency: result, flags and parity are registered and visible the cycle after accept.
// Backpressure: in_ready = !out_valid || out_ready; the held result stays stable while out_ready is low.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
`ifdef LOGIC_UNIT_PARITY_EN
    output logic             parity,
`endif
    output logic [CNT_W-1:0] op_count
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] res;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        left = acc_mode ? acc : a;
        res  = '0;
        case (op)
            3'd0:    res = left & b;
            3'd1:    res = left | b;
            3'd2:    res = ~left;
            3'd3:    res = ~(left & b);
            3'd4:    res = ~(left | b);
            3'd5:    res = left ^ b;
            3'd6:    res = ~(left ^ b);
            default: res = left;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            ones      <= 1'b0;
            op_count  <= '0;
            acc       <= '0;
`ifdef LOGIC_UNIT_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                y         <= res;
                zero      <= ~|res;
                ones      <= &res;
                op_count  <= op_count + CNT_W'(1);
`ifdef LOGIC_UNIT_PARITY_EN
                parity    <= ^res;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // clear wins over an accumulate in the same cycle; the op still saw the old value
            if (acc_clr)
                acc <= '0;
            else if (accept && acc_mode)
                acc <= res;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe; a second instance with CNT_W=2 shares all inputs.
module tb_logic_unit_pipe;

    logic       clk, rst_n, in_valid, out_ready, acc_mode, acc_clr;
    logic [7:0] a, b;
    logic [2:0] op;
    logic       in_ready, out_valid, zero, ones;
    logic [7:0] y;
    logic [15:0] op_count;
    logic       in_ready_w, out_valid_w, zero_w, ones_w;
    logic [7:0] y_w;
    logic [1:0] op_count_w;
`ifdef LOGIC_UNIT_PARITY_EN
    logic       parity, parity_w;
`endif

    int errors = 0;
    int checks = 0;

    // reference state
    logic        m_valid, m_zero, m_ones;
    logic [7:0]  m_y, m_acc;
    logic [15:0] m_cnt;

    logic [7:0] sweep_exp [8];

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero), .ones(ones),
`ifdef LOGIC_UNIT_PARITY_EN
        .parity(parity),
`endif
        .op_count(op_count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid_w), .out_ready(out_ready), .y(y_w), .zero(zero_w), .ones(ones_w),
`ifdef LOGIC_UNIT_PARITY_EN
        .parity(parity_w),
`endif
        .op_count(op_count_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] l, input logic [7:0] r);
        case (o)
            3'd0:    return l & r;
            3'd1:    return l | r;
            3'd2:    return ~l;
            3'd3:    return ~(l & r);
            3'd4:    return ~(l | r);
            3'd5:    return l ^ r;
            3'd6:    return ~(l ^ r);
            default: return l;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_zero = 1'b0; m_ones = 1'b0;
        m_y = 8'h00; m_acc = 8'h00; m_cnt = 16'd0;
    endtask

    // advance one clock, update the reference from the inputs seen at the edge, return #1 after it
    task automatic step();
        logic       take;
        logic [7:0] r;
        take = in_valid && (!m_valid || out_ready);
        @(posedge clk);
        if (take) begin
            r = ref_f(op, acc_mode ? m_acc : a, b);
            m_y = r; m_zero = (r == 8'h00); m_ones = (r == 8'hFF);
            m_valid = 1'b1; m_cnt = m_cnt + 16'd1;
            if (acc_mode) m_acc = r;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (acc_clr) m_acc = 8'h00;
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; acc_mode = 0; acc_clr = 0; a = 0; b = 0; op = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; out_ready = 0; idle_inputs();
        model_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL rst_y got=%h exp=00", y); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        in_valid = 1; a = 8'hFF; op = 3'd7;
        step();
        in_valid = 0;
        step();
        checks++; if (y !== 8'hFF || out_valid !== 1'b1) begin errors++; $display("FAIL rst_pending got=%h/%b exp=ff/1", y, out_valid); end
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || y !== 8'h00 || op_count !== 16'd0)
            begin errors++; $display("FAIL rst_async got=%b/%h/%0d exp=0/00/0", out_valid, y, op_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%b exp=1", in_ready); end
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_opcode_sweep();
        out_ready = 1; a = 8'hF0; b = 8'h3C; in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            step();
            checks++; if (y !== sweep_exp[i] || out_valid !== 1'b1)
                begin errors++; $display("FAIL sweep_op%0d got=%h exp=%h", i, y, sweep_exp[i]); end
        end
        in_valid = 0;
        checks++; if (op_count !== 16'd8) begin errors++; $display("FAIL sweep_count got=%0d exp=8", op_count); end
        step();
        checks++; if (out_valid !== 1'b0 || y !== 8'hF0) begin errors++; $display("FAIL sweep_drain got=%b/%h exp=0/f0", out_valid, y); end
    endtask

    task automatic test_backpressure();
        out_ready = 0; in_valid = 1; a = 8'hAA; b = 8'h55; op = 3'd1;
        step();
        checks++; if (y !== 8'hFF || ones !== 1'b1 || out_valid !== 1'b1)
            begin errors++; $display("FAIL bp_first got=%h/%b/%b exp=ff/1/1", y, ones, out_valid); end
        a = 8'h0F; b = 8'hF0; op = 3'd0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d in_ready got=%b exp=0", i, in_ready); end
            step();
            checks++; if (y !== 8'hFF) begin errors++; $display("FAIL bp_hold%0d got=%h exp=ff", i, y); end
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready got=%b exp=1", in_ready); end
        step();
        checks++; if (y !== 8'h00 || zero !== 1'b1 || ones !== 1'b0 || out_valid !== 1'b1)
            begin errors++; $display("FAIL bp_second got=%h/%b/%b/%b exp=00/1/0/1", y, zero, ones, out_valid); end
        in_valid = 0;
        step();
    endtask

    task automatic test_accumulate();
        logic [7:0] bs [5];
        logic [2:0] os [5];
        logic [7:0] es [5];
        bs = '{8'h01, 8'h02, 8'h04, 8'hFF, 8'h00};
        os = '{3'd1, 3'd1, 3'd1, 3'd5, 3'd2};
        es = '{8'h01, 8'h03, 8'h07, 8'hF8, 8'h07};
        acc_clr = 1; step(); acc_clr = 0;
        out_ready = 1; acc_mode = 1; in_valid = 1; a = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            b = bs[i]; op = os[i];
            step();
            checks++; if (y !== es[i]) begin errors++; $display("FAIL acc_step%0d got=%h exp=%h", i, y, es[i]); end
`ifdef LOGIC_UNIT_PARITY_EN
            checks++; if (parity !== ^es[i]) begin errors++; $display("FAIL acc_parity%0d got=%b exp=%b", i, parity, ^es[i]); end
`endif
        end
        in_valid = 0; acc_mode = 0;
        step();
    endtask

    task automatic test_clear_collision();
        in_valid = 1; acc_mode = 1; op = 3'd7; acc_clr = 1; out_ready = 1;
        step();
        checks++; if (y !== 8'h07) begin errors++; $display("FAIL clr_same got=%h exp=07", y); end
        acc_clr = 0;
        step();
        checks++; if (y !== 8'h00 || zero !== 1'b1) begin errors++; $display("FAIL clr_after got=%h/%b exp=00/1", y, zero); end
        idle_inputs();
        step();
    endtask

    task automatic test_flags_wrap();
        #2 rst_n = 0; #1 model_reset();
        @(negedge clk); rst_n = 1;
        out_ready = 1; in_valid = 1; a = 8'h0F; b = 8'hF0; op = 3'd0;
        step();
        checks++; if (zero !== 1'b1 || ones !== 1'b0) begin errors++; $display("FAIL flags_and got=%b/%b exp=1/0", zero, ones); end
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); op = 3'($urandom_range(0, 7));
            step();
        end
        in_valid = 0;
        step();
        checks++; if (op_count_w !== 2'd1) begin errors++; $display("FAIL wrap_cnt2 got=%0d exp=1", op_count_w); end
        checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL wrap_cnt16 got=%0d exp=5", op_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = 8'($urandom); b = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            acc_mode = $urandom_range(0, 1) == 1;
            acc_clr  = ($urandom_range(0, 9) == 0);
            #1;
            checks++; if (in_ready !== (!m_valid || out_ready))
                begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, in_ready, !m_valid || out_ready); end
            step();
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, m_valid); end
            checks++; if (y !== m_y || y_w !== m_y) begin errors++; $display("FAIL rnd_y cyc=%0d got=%h/%h exp=%h", i, y, y_w, m_y); end
            checks++; if (zero !== m_zero || ones !== m_ones)
                begin errors++; $display("FAIL rnd_flags cyc=%0d got=%b%b exp=%b%b", i, zero, ones, m_zero, m_ones); end
            checks++; if (op_count !== m_cnt || op_count_w !== m_cnt[1:0])
                begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d", i, op_count, op_count_w, m_cnt); end
`ifdef LOGIC_UNIT_PARITY_EN
            checks++; if (parity !== ^m_y) begin errors++; $display("FAIL rnd_parity cyc=%0d got=%b exp=%b", i, parity, ^m_y); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        sweep_exp = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0};
        test_reset();
        test_opcode_sweep();
        test_backpressure();
        test_accumulate();
        test_clear_collision();
        test_flags_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's bitwise gate block.
- Applies one of eight bitwise functions to WIDTH-bit operands, selected per transfer by an opcode.
- Registers the result behind a valid/ready handshake.
- Optional accumulate mode folds each result into an internal accumulator, for building chained bitwise reductions in datapath blocks.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 16, width of accepted-transfer counter (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transfer offered
- in_ready  output  1  block can accept a transfer this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  function select, sampled on accept
- acc_mode  input  1  1: left operand is the accumulator instead of a; sampled on accept
- acc_clr  input  1  synchronous accumulator clear
- out_valid  output  1  y holds a valid result
- out_ready  input  1  downstream accepts result
- y  output  WIDTH  registered result
- zero  output  1  registered: result was all zeros
- ones  output  1  registered: result was all ones
- op_count  output  CNT_W  number of accepted transfers, modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous): out_valid=0, y=0, zero=0, ones=0, op_count=0, accumulator=0.
  - in_ready=1 while in reset and after release.
  - Reset mid-transfer discards the held result.
- Opcode encoding, with L = left operand:
  - 0 AND: L&b
  - 1 OR: L|b
  - 2 NOT: ~L, b ignored
  - 3 NAND: ~(L&b)
  - 4 NOR: ~(L|b)
  - 5 XOR: L^b
  - 6 XNOR: ~(L^b)
  - 7 PASS: L
- Left operand: L = acc_mode ? accumulator : a.
- in_ready = !out_valid || out_ready (combinational); a full-throughput single-stage register.
- Accept = in_valid && in_ready. On accept:
  - y <= f(op, L, b); zero <= (f==0); ones <= (f==all ones); out_valid <= 1.
  - op_count increments and wraps from 2^CNT_W-1 to 0.
  - If acc_mode=1, the accumulator <= f.
- Latency: result visible the cycle after accept.
- If out_valid=1 and out_ready=1 with no accept, out_valid <= 0 in the next cycle; y, zero and ones keep their last values.
- If out_valid=1 and out_ready=0: y, zero, ones and out_valid are held stable; in_ready=0.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): the new result replaces the old one with no bubble, and out_valid stays 1.
- acc_clr=1: the accumulator <= 0 at the next edge.
  - If it coincides with an accept in acc_mode, the operation uses the old accumulator value for L and y shows that result, but the accumulator ends at 0 (clear wins).
  - acc_clr does not affect y, out_valid or op_count.
- acc_mode=0 transfers never modify the accumulator.
- Operands are treated as unsigned bit vectors; there is no arithmetic and no carry.

Optional Feature:
- Macro: LOGIC_UNIT_PARITY_EN.
- Defined: adds output port parity (1 bit).
  - Registered alongside y as the XOR-reduction of the result, updated only on accept.
  - Reset value 0; held under backpressure like y.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold out_ready=0 with a result pending (out_valid=1, y=FF), then pulse rst_n=0 between edges -> out_valid, y and op_count go to 0 immediately (no clock edge) and in_ready=1.
2. Opcode sweep (WIDTH=8): out_ready=1, a=F0, b=3C, op 0..7 on consecutive cycles.
   - Expected y per op: 30, FC, 0F, CF, 03, CC, 33, F0.
   - Each result appears one cycle after its accept; op_count=8 at the end.
3. Backpressure:
   - out_ready=0, send a=AA b=55 op=1 -> y=FF, ones=1, out_valid=1.
   - The next transfer is held with in_ready=0 for 3 cycles while y stays FF.
   - Raise out_ready -> the second transfer is accepted in the same cycle, and out_valid stays 1.
4. Accumulate: pulse acc_clr, then acc_mode=1, op=1, b=01, 02, 04 -> y=01, 03, 07. Then op=5, b=FF -> y=F8. Then op=2 -> y=07.
5. Clear collision: accumulator=07; acc_clr=1 together with an accept (acc_mode=1, op=7) -> y=07. Next accept (acc_mode=1, op=7) -> y=00.
6. Flags, counter wrap and parity:
   - AND a=0F b=F0 -> zero=1, ones=0.
   - With CNT_W=2, 5 accepts -> op_count=1.
   - With LOGIC_UNIT_PARITY_EN defined, result y=07 -> parity=1; result y=03 -> parity=0.
